// File: rtl/load_use_stall_unit_pkg.sv
// Shared pipeline definitions for the load-use stall stage: register address
// width, control-enable bundle and stall FSM states.
package load_use_stall_unit_pkg;

    localparam int REG_ADDR_W = 3;

    typedef struct packed {
        logic pc_write_en;
        logic ifid_write_en;
        logic idex_bubble;
    } ctl_t;

    localparam ctl_t CTL_RUN   = '{pc_write_en: 1'b1, ifid_write_en: 1'b1, idex_bubble: 1'b0};
    localparam ctl_t CTL_STALL = '{pc_write_en: 1'b0, ifid_write_en: 1'b0, idex_bubble: 1'b1};
    localparam ctl_t CTL_FLUSH = '{pc_write_en: 1'b1, ifid_write_en: 1'b1, idex_bubble: 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } stall_state_t;

endpackage

// File: rtl/load_use_stall_unit_if.sv
// ID/EX hazard inputs and pipeline-control outputs of the load-use stall unit.
interface load_use_stall_unit_if #(
    parameter int CNT_W = 16
);
    import load_use_stall_unit_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rsrc_addr;
    logic [REG_ADDR_W-1:0] id_rdst_addr;
    logic                  id_uses_rsrc;
    logic                  id_uses_rdst;
    logic                  ex_valid;
    logic                  ex_mem_read;
    logic                  ex_reg_write;
    logic [REG_ADDR_W-1:0] ex_write_addr;
    logic                  branch_flush;
    logic                  pc_write_en;
    logic                  ifid_write_en;
    logic                  idex_bubble;
    logic                  stall_active;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_valid, id_rsrc_addr, id_rdst_addr, id_uses_rsrc, id_uses_rdst,
        output ex_valid, ex_mem_read, ex_reg_write, ex_write_addr, branch_flush,
        input  pc_write_en, ifid_write_en, idex_bubble, stall_active, stall_cycles
    );

    modport slave (
        input  id_valid, id_rsrc_addr, id_rdst_addr, id_uses_rsrc, id_uses_rdst,
        input  ex_valid, ex_mem_read, ex_reg_write, ex_write_addr, branch_flush,
        output pc_write_en, ifid_write_en, idex_bubble, stall_active, stall_cycles
    );

endinterface

// File: rtl/load_use_stall_unit_hazard_compare.sv
// Pure combinational producer/consumer hazard check; a consumer operand matches a
// pending register write of a load in flight.
module hazard_compare
    import load_use_stall_unit_pkg::*;
(
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rsrc_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rdst_addr,
    input  logic                  i_id_uses_rsrc,
    input  logic                  i_id_uses_rdst,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_reg_write,
    input  logic [REG_ADDR_W-1:0] i_ex_write_addr,
    output logic                  o_hazard
);

    logic w_src_match;
    logic w_dst_match;
    logic w_producer;

    // R0 is an ordinary register, so a plain full-width compare is correct.
    assign w_src_match = i_id_uses_rsrc && (i_id_rsrc_addr == i_ex_write_addr);
    assign w_dst_match = i_id_uses_rdst && (i_id_rdst_addr == i_ex_write_addr);
    assign w_producer  = i_ex_valid && i_ex_mem_read && i_ex_reg_write;
    assign o_hazard    = i_id_valid && w_producer && (w_src_match || w_dst_match);

endmodule

// File: rtl/load_use_stall_unit.sv
// Load-use stall stage: freezes PC/IF-ID and bubbles ID/EX for MEM_LATENCY cycles
// per load-use hazard, applies branch flushes, counts stalled cycles.
module load_use_stall_unit
    import load_use_stall_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    load_use_stall_unit_if.slave bus
);

    stall_state_t     r_state;
    stall_state_t     w_state_nxt;
    logic [2:0]       r_remain;
    logic [2:0]       w_remain_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_hazard;
    logic             w_stall;
    ctl_t             w_ctl;

    localparam logic [2:0] HOLD_LOAD = 3'(MEM_LATENCY - 1);

    hazard_compare u_hazard_compare (
        .i_id_valid      (bus.id_valid),
        .i_id_rsrc_addr  (bus.id_rsrc_addr),
        .i_id_rdst_addr  (bus.id_rdst_addr),
        .i_id_uses_rsrc  (bus.id_uses_rsrc),
        .i_id_uses_rdst  (bus.id_uses_rdst),
        .i_ex_valid      (bus.ex_valid),
        .i_ex_mem_read   (bus.ex_mem_read),
        .i_ex_reg_write  (bus.ex_reg_write),
        .i_ex_write_addr (bus.ex_write_addr),
        .o_hazard        (w_hazard)
    );

    always_ff @(posedge clk) begin
        r_state  <= w_state_nxt;
        r_remain <= w_remain_nxt;
    end

    // Reset and flush both squash the ID/EX slot but let fetch proceed.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_ctl        = CTL_RUN;
        w_stall      = 1'b0;
        if (rst || bus.branch_flush) begin
            w_ctl        = CTL_FLUSH;
            w_state_nxt  = IDLE;
            w_remain_nxt = 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hazard) begin
                        w_ctl   = CTL_STALL;
                        w_stall = 1'b1;
                        if (MEM_LATENCY > 1) begin
                            w_state_nxt  = HOLD;
                            w_remain_nxt = HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    // EX holds our own bubble here, so ID/EX inputs are ignored.
                    w_ctl        = CTL_STALL;
                    w_stall      = 1'b1;
                    w_remain_nxt = r_remain - 3'd1;
                    if (r_remain == 3'd1) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_remain_nxt = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign bus.pc_write_en   = w_ctl.pc_write_en;
    assign bus.ifid_write_en = w_ctl.ifid_write_en;
    assign bus.idex_bubble   = w_ctl.idex_bubble;
    assign bus.stall_active  = w_stall;
    assign bus.stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_load_use_stall_unit.sv
// Directed bench: vector table on a 1-cycle-latency unit, hand sequences on a
// 3-cycle-latency unit with a narrow counter for saturation.
module tb_load_use_stall_unit;
    import load_use_stall_unit_pkg::*;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_pass;
    int   n_tot;

    localparam logic [3:0] RUN = 4'b1100;
    localparam logic [3:0] STL = 4'b0011;
    localparam logic [3:0] FLU = 4'b1110;

    load_use_stall_unit_if #(.CNT_W(16)) ia ();
    load_use_stall_unit_if #(.CNT_W(4))  ib ();

    load_use_stall_unit #(.MEM_LATENCY(1), .CNT_W(16)) u_dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
    load_use_stall_unit #(.MEM_LATENCY(3), .CNT_W(4))  u_dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       idv;
        logic [2:0] rs;
        logic [2:0] rd;
        logic       urs;
        logic       urd;
        logic       exv;
        logic       mr;
        logic       rw;
        logic [2:0] wa;
        logic       fl;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [3:0] ctl_a();
        return {ia.pc_write_en, ia.ifid_write_en, ia.idex_bubble, ia.stall_active};
    endfunction

    function automatic logic [3:0] ctl_b();
        return {ib.pc_write_en, ib.ifid_write_en, ib.idex_bubble, ib.stall_active};
    endfunction

    // One cycle on unit B: hazard means ID R3 source vs EX load to R3.
    task automatic b_cyc(input logic haz, input logic fl, input logic r,
                         input logic [3:0] exp, input string name);
        ib.id_valid      = 1'b1;
        ib.id_rsrc_addr  = 3'd3;
        ib.id_rdst_addr  = 3'd6;
        ib.id_uses_rsrc  = 1'b1;
        ib.id_uses_rdst  = 1'b0;
        ib.ex_valid      = haz;
        ib.ex_mem_read   = haz;
        ib.ex_reg_write  = 1'b1;
        ib.ex_write_addr = haz ? 3'd3 : 3'd1;
        ib.branch_flush  = fl;
        rst_b            = r;
        #1;
        chk(name, 32'(ctl_b()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic b_stall3(input string name);
        b_cyc(1'b1, 1'b0, 1'b0, STL, name);
        b_cyc(1'b0, 1'b0, 1'b0, STL, name);
        b_cyc(1'b0, 1'b0, 1'b0, STL, name);
    endtask

    initial begin
        int exp_cnt;
        n_pass = 0;
        n_tot  = 0;
        //          idv   rs    rd    urs   urd   exv   mr    rw    wa    fl    exp
        vecs[0]  = '{1'b1, 3'd3, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, STL};
        vecs[1]  = '{1'b0, 3'd3, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, RUN};
        vecs[2]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, RUN};
        vecs[3]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, STL};
        vecs[4]  = '{1'b1, 3'd2, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, RUN};
        vecs[5]  = '{1'b1, 3'd0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, STL};
        vecs[6]  = '{1'b1, 3'd3, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, RUN};
        vecs[7]  = '{1'b1, 3'd3, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, RUN};
        vecs[8]  = '{1'b1, 3'd3, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, FLU};
        vecs[9]  = '{1'b1, 3'd4, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, RUN};
        vecs[10] = '{1'b1, 3'd3, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, RUN};
        vecs[11] = '{1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, STL};

        // Reset phase on both units, with a live hazard present on A.
        rst_a = 1'b1;
        ia.id_valid = 1'b1; ia.id_rsrc_addr = 3'd3; ia.id_rdst_addr = 3'd6;
        ia.id_uses_rsrc = 1'b1; ia.id_uses_rdst = 1'b0; ia.ex_valid = 1'b1;
        ia.ex_mem_read = 1'b1; ia.ex_reg_write = 1'b1; ia.ex_write_addr = 3'd3;
        ia.branch_flush = 1'b0;
        b_cyc(1'b0, 1'b0, 1'b1, FLU, "rst_ctl_b");
        chk("rst_ctl_a", 32'(ctl_a()), 32'(FLU));
        chk("rst_cnt_a", 32'(ia.stall_cycles), 32'd0);
        chk("rst_cnt_b", 32'(ib.stall_cycles), 32'd0);
        rst_a = 1'b0;

        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            ia.id_valid      = vecs[i].idv;
            ia.id_rsrc_addr  = vecs[i].rs;
            ia.id_rdst_addr  = vecs[i].rd;
            ia.id_uses_rsrc  = vecs[i].urs;
            ia.id_uses_rdst  = vecs[i].urd;
            ia.ex_valid      = vecs[i].exv;
            ia.ex_mem_read   = vecs[i].mr;
            ia.ex_reg_write  = vecs[i].rw;
            ia.ex_write_addr = vecs[i].wa;
            ia.branch_flush  = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a()), 32'(vecs[i].exp));
            if (vecs[i].exp[0]) exp_cnt++;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cnt", i), 32'(ia.stall_cycles), 32'(exp_cnt));
        end

        // Latency 3: stall holds even after the EX load disappears.
        b_stall3("lat3");
        b_cyc(1'b0, 1'b0, 1'b0, RUN, "lat3_release");
        chk("lat3_cnt", 32'(ib.stall_cycles), 32'd3);

        // Persistent hazard: re-evaluated on return to IDLE, new stall starts.
        b_cyc(1'b1, 1'b0, 1'b0, STL, "b2b_c1");
        b_cyc(1'b1, 1'b0, 1'b0, STL, "b2b_c2");
        b_cyc(1'b1, 1'b0, 1'b0, STL, "b2b_c3");
        b_cyc(1'b1, 1'b0, 1'b0, STL, "b2b_second");
        b_cyc(1'b0, 1'b0, 1'b0, STL, "b2b_hold");
        b_cyc(1'b0, 1'b0, 1'b0, STL, "b2b_hold");
        b_cyc(1'b0, 1'b0, 1'b0, RUN, "b2b_release");
        chk("b2b_cnt", 32'(ib.stall_cycles), 32'd9);

        // Branch flush in the second stall cycle.
        b_cyc(1'b0, 1'b0, 1'b1, FLU, "rst2");
        b_cyc(1'b1, 1'b0, 1'b0, STL, "flush_c1");
        b_cyc(1'b0, 1'b1, 1'b0, FLU, "flush_hold");
        b_cyc(1'b0, 1'b0, 1'b0, RUN, "flush_after");
        chk("flush_cnt", 32'(ib.stall_cycles), 32'd1);

        // Reset in the middle of a hold.
        b_cyc(1'b1, 1'b0, 1'b0, STL, "rsthold_c1");
        b_cyc(1'b0, 1'b0, 1'b1, FLU, "rsthold_rst");
        b_cyc(1'b0, 1'b0, 1'b0, RUN, "rsthold_after");
        chk("rsthold_cnt", 32'(ib.stall_cycles), 32'd0);

        // Bring the 4-bit counter to 13, then a 3-cycle stall saturates it.
        for (int k = 0; k < 4; k++) b_stall3("sat_fill");
        b_cyc(1'b1, 1'b0, 1'b0, STL, "sat_fill1");
        b_cyc(1'b0, 1'b1, 1'b0, FLU, "sat_flush");
        chk("sat_pre", 32'(ib.stall_cycles), 32'd13);
        b_cyc(1'b1, 1'b0, 1'b0, STL, "sat_c1");
        chk("sat_14", 32'(ib.stall_cycles), 32'd14);
        b_cyc(1'b0, 1'b0, 1'b0, STL, "sat_c2");
        chk("sat_15", 32'(ib.stall_cycles), 32'd15);
        b_cyc(1'b0, 1'b0, 1'b0, STL, "sat_c3");
        chk("sat_hold", 32'(ib.stall_cycles), 32'd15);
        b_cyc(1'b0, 1'b0, 1'b0, RUN, "sat_release");
        chk("sat_final", 32'(ib.stall_cycles), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
